score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Multi-digit BCD score register for the Flappy Bird datapath. Sits directly
//  downstream of the pipe-pass detector and upstream of the HEX display
//  decoders. Uses the per-digit BCD increment rule (0..9, 9->0 with carry).
//  Runs a small game-state FSM that gates counting: score counts only during
//  play and freezes on crash.
// PARAMETERS
//  NUM_DIGITS  2  number of BCD digits; score range 0 .. 10^NUM_DIGITS-1
//  SATURATE    1  1: hold at max (all 9s); 0: wrap to all 0s
// PORTS
//  clk        in   1               system clock; all state updates on posedge
//  reset_n    in   1               synchronous active-low reset
//  start      in   1               level; begin/restart game
//  point      in   1               level from pass detector; one point per rising edge
//  crash      in   1               level from collision logic
//  score      out  4*NUM_DIGITS    BCD score; digit 0 = score[3:0]
//  playing    out  1               1 while FSM in PLAY
//  game_over  out  1               1 while FSM in OVER
//  max_hit    out  1               SATURATE=1: sticky, set when held at max;
//                                  SATURATE=0: 1-cycle pulse on wrap
//  best       out  4*NUM_DIGITS    high score (see CONFIGURATION)
// BEHAVIOUR
//  - One clock domain. Reset is synchronous, active-low, on reset_n.
//  - Reset (reset_n=0 at posedge): FSM=IDLE, score=0, point_q=0, max_hit=0,
//    playing=0, game_over=0, best=0. Reset mid-game aborts the game.
//  - Edge detect: point_q <= point every cycle in every state.
//    inc = point & ~point_q & (state==PLAY).
//  - Latency: score shows the new value one cycle after the posedge where
//    inc=1. A point held high for N cycles counts exactly once.
//  - Increment: ripple carry from digit 0. Digit d increments iff all lower
//    digits are 9. Per-digit rule: 0..8 -> +1; 9 -> 0 with carry;
//    codes 10..15 -> 0 with no carry (illegal-state recovery).
//  - Top carry-out (score at all 9s): SATURATE=1 holds all 9s and sets
//    max_hit until the next clear. SATURATE=0 goes to all 0s and pulses
//    max_hit for 1 cycle.
//  - FSM (registered, Moore outputs):
//      IDLE -start-> PLAY   score<=0, max_hit<=0
//      PLAY -crash-> OVER   score frozen
//      OVER -start-> PLAY   score<=0, max_hit<=0
//    All other inputs leave the state unchanged. playing=(PLAY),
//    game_over=(OVER).
//  - Simultaneous events:
//      crash & inc in PLAY        -> crash wins; the point is not counted.
//      start & crash in PLAY      -> crash wins (go to OVER).
//      start in PLAY              -> ignored.
//      start & point on the IDLE->PLAY edge -> score=0; the point is not
//        counted. point_q still updates, so a level held high does not
//        count later.
//  - score is a direct register output, with no combinational path from
//    any input.
// CONFIGURATION
//  - SCORE_HIGH_SCORE_EN defined: best register holds the maximum final score.
//    On the PLAY->OVER transition, best<=score if score>best. Compare as
//    unsigned; BCD order equals numeric order. best survives restarts and
//    clears only on reset.
//  - SCORE_HIGH_SCORE_EN undefined: no best register; best is tied to 0.
// TESTING
//  1. reset_n=0 for 2 cycles, then 1 -> score=00, playing=0, game_over=0,
//     max_hit=0.
//  2. start pulse, then 3 separate point pulses, one held 5 cycles
//     -> score=03; each update lands 1 cycle after its rising edge.
//  3. NUM_DIGITS=2: from score 09 a point -> 10; drive to 99 and point again
//     -> SATURATE=1: 99 with max_hit=1; SATURATE=0: 00 with a 1-cycle
//     max_hit pulse.
//  4. In PLAY at score 05, crash and a point rising edge in the same cycle
//     -> OVER, score stays 05. Further points ignored. start -> PLAY,
//     score=00.
//  5. Score 07 mid-PLAY, reset_n=0 for 1 cycle -> IDLE, score=00, best=00.
//  6. SCORE_HIGH_SCORE_EN: game ending at 12, then game ending at 04
//     -> best=12 after each. Macro undefined -> best=00 throughout.

Source files
------------

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Multi-digit BCD score register for the Flappy Bird datapath. It takes
//   point pulses from the pipe-pass detector and drives the HEX display
//   decoders. A small game-state FSM (IDLE -> PLAY -> OVER) gates counting:
//   points count only in PLAY, and the score freezes on a crash.
//
// Parameters
//   NUM_DIGITS  number of BCD digits (score range 0 .. 10^NUM_DIGITS-1)
//   SATURATE    1: hold at all 9s, max_hit sticky; 0: wrap to 0, max_hit pulse
//
// Ports
//   clk        in   system clock, all state changes on posedge
//   reset_n    in   synchronous active-low reset
//   start      in   level, begins or restarts a game from IDLE/OVER
//   point      in   level from pass detector, one point per rising edge
//   crash      in   level from collision logic, ends the game
//   score      out  BCD score, digit 0 = score[3:0]
//   playing    out  1 while in PLAY
//   game_over  out  1 while in OVER
//   max_hit    out  top-digit carry indicator (sticky or pulse, see SATURATE)
//   best       out  high score
//
// Build option
//   SCORE_HIGH_SCORE_EN : when defined, best holds the highest final score
//   since reset (captured on PLAY->OVER). When undefined, best is tied to 0.
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int NUM_DIGITS = 2,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    point,
  input  logic                    crash,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic                    playing,
  output logic                    game_over,
  output logic                    max_hit,
  output logic [4*NUM_DIGITS-1:0] best
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};
  localparam logic [W-1:0] ALL_ZEROS = {W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t         state_r;
  logic [W-1:0]   score_r;
  logic           point_q_r;
  logic           max_hit_r;
  logic           playing_r;
  logic           game_over_r;

  logic           inc_s;
  logic [W:0]     inc_res_s;

  // Ripple-carry BCD increment. Returns {carry_out, next_value}.
  // A digit holding an illegal code (10..15) is forced to 0 and swallows the
  // carry so a corrupted register recovers without disturbing upper digits.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   dg;
    r = v;
    c = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      dg = v[4*d +: 4];
      if (c) begin
        if (dg < 4'd9) begin
          r[4*d +: 4] = dg + 4'd1;
          c = 1'b0;
        end else if (dg == 4'd9) begin
          r[4*d +: 4] = 4'd0;
          c = 1'b1;
        end else begin
          r[4*d +: 4] = 4'd0;
          c = 1'b0;
        end
      end else begin
        r[4*d +: 4] = dg;
      end
    end
    return {c, r};
  endfunction

  // Rising-edge point detect, qualified by PLAY, and the candidate next score.
  always_comb begin
    inc_s     = point & ~point_q_r & (state_r == PLAY);
    inc_res_s = bcd_inc(score_r);
  end

  // Game FSM with registered Moore outputs, score register and max_hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      score_r     <= ALL_ZEROS;
      point_q_r   <= 1'b0;
      max_hit_r   <= 1'b0;
      playing_r   <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      // Edge detector tracks point in every state so a level held across
      // a start does not count later.
      point_q_r <= point;
      // In wrap mode max_hit is a single-cycle pulse.
      if (!SATURATE) begin
        max_hit_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= PLAY;
            playing_r   <= 1'b1;
            game_over_r <= 1'b0;
            score_r     <= ALL_ZEROS;
            max_hit_r   <= 1'b0;
          end
        end
        PLAY: begin
          // Crash has priority over both start and a coincident point.
          if (crash) begin
            state_r     <= OVER;
            playing_r   <= 1'b0;
            game_over_r <= 1'b1;
          end else if (inc_s) begin
            if (inc_res_s[W]) begin
              max_hit_r <= 1'b1;
              score_r   <= SATURATE ? ALL_NINES : inc_res_s[W-1:0];
            end else begin
              score_r   <= inc_res_s[W-1:0];
            end
          end
        end
        OVER: begin
          if (start) begin
            state_r     <= PLAY;
            playing_r   <= 1'b1;
            game_over_r <= 1'b0;
            score_r     <= ALL_ZEROS;
            max_hit_r   <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          playing_r   <= 1'b0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign score     = score_r;
  assign playing   = playing_r;
  assign game_over = game_over_r;
  assign max_hit   = max_hit_r;

`ifdef SCORE_HIGH_SCORE_EN
  logic [W-1:0] best_r;

  // High score capture on the PLAY->OVER transition; BCD compares as unsigned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      best_r <= ALL_ZEROS;
    end else if ((state_r == PLAY) && crash && (score_r > best_r)) begin
      best_r <= score_r;
    end
  end

  assign best = best_r;
`else
  assign best = ALL_ZEROS;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Self-checking bench for score_keeper. Two instances share the stimulus:
//   dut (SATURATE=1) and dut_wrap (SATURATE=0), both NUM_DIGITS=2.
//   A table of vectors covers reset and basic counting; hand-written
//   sequences cover carry, saturation/wrap, crash priority, mid-game reset
//   and high-score tracking.
// -----------------------------------------------------------------------------
module tb_score_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, point, crash;
  logic [7:0] score, score_w, best, best_w;
  logic       playing, game_over, max_hit;
  logic       playing_w, game_over_w, max_hit_w;

  score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .point(point), .crash(crash),
    .score(score), .playing(playing), .game_over(game_over),
    .max_hit(max_hit), .best(best)
  );

  score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .point(point), .crash(crash),
    .score(score_w), .playing(playing_w), .game_over(game_over_w),
    .max_hit(max_hit_w), .best(best_w)
  );

  typedef struct {
    logic rn, st, pt, cr;
    int   sc, scw;
    logic pl, ov, mh, mhw;
    int   bs, bsw;
  } vec_t;

  vec_t q[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Running expectations for the hand-written sequences.
  int   cur, curw, bs, bsw;
  logic pl, ov, mh, mhw;

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  function automatic vec_t mkv(input logic rn, input logic st, input logic pt,
                               input logic cr, input int sc, input logic p);
    vec_t v;
    v.rn = rn; v.st = st; v.pt = pt; v.cr = cr;
    v.sc = sc; v.scw = sc; v.pl = p; v.ov = 1'b0;
    v.mh = 1'b0; v.mhw = 1'b0; v.bs = 0; v.bsw = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    q.push_back(v);
    reset_n = v.rn; start = v.st; point = v.pt; crash = v.cr;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("score",       score,                  bcd(e.sc));
    chk("score_wrap",  score_w,                bcd(e.scw));
    chk("playing",     {7'd0, playing},        {7'd0, e.pl});
    chk("game_over",   {7'd0, game_over},      {7'd0, e.ov});
    chk("playing_w",   {7'd0, playing_w},      {7'd0, e.pl});
    chk("game_over_w", {7'd0, game_over_w},    {7'd0, e.ov});
    chk("max_hit",     {7'd0, max_hit},        {7'd0, e.mh});
    chk("max_hit_w",   {7'd0, max_hit_w},      {7'd0, e.mhw});
`ifdef SCORE_HIGH_SCORE_EN
    chk("best",        best,                   bcd(e.bs));
    chk("best_w",      best_w,                 bcd(e.bsw));
`else
    chk("best",        best,                   8'h00);
    chk("best_w",      best_w,                 8'h00);
`endif
  endtask

  task automatic step(input logic rn, input logic st, input logic pt, input logic cr);
    vec_t v;
    v.rn = rn; v.st = st; v.pt = pt; v.cr = cr;
    v.sc = cur; v.scw = curw; v.pl = pl; v.ov = ov;
    v.mh = mh; v.mhw = mhw; v.bs = bs; v.bsw = bsw;
    apply(v);
  endtask

  // One point: rising edge counts on the first cycle, then release.
  task automatic pulse();
    cur++;
    curw++;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset, IDLE ignores points, start edge with point, held point, 3 points.
    //             rn    st    pt    cr   sc  playing
    tbl[0]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    tbl[5]  = mkv(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    tbl[6]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    tbl[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    tbl[8]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tbl[9]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tbl[10] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tbl[11] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tbl[12] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    tbl[13] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    tbl[14] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1);
    tbl[15] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    tbl[16] = mkv(1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    tbl[17] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i]);
    end

    cur = 3; curw = 3; pl = 1'b1; ov = 1'b0;
    mh = 1'b0; mhw = 1'b0; bs = 0; bsw = 0;

    // Count up through 09->10 and every other carry to 99.
    while (cur < 99) pulse();

    // One more point at 99: saturate holds, wrap goes to 00 with a pulse.
    mh = 1'b1; mhw = 1'b1; curw = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    mhw = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    curw = 1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Crash ends the game; points in OVER are ignored.
    pl = 1'b0; ov = 1'b1; bs = 99; bsw = 1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Restart clears score and sticky max_hit.
    pl = 1'b1; ov = 1'b0; cur = 0; curw = 0; mh = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Crash and point edge together at 05: crash wins, score frozen.
    repeat (5) pulse();
    pl = 1'b0; ov = 1'b1; bsw = 5;
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    pl = 1'b1; ov = 1'b0; cur = 0; curw = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);

    // Mid-game reset at 07 aborts the game and clears the high score.
    repeat (7) pulse();
    cur = 0; curw = 0; pl = 1'b0; ov = 1'b0; mh = 1'b0; mhw = 1'b0;
    bs = 0; bsw = 0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // High score: game ends at 12 (start&crash -> crash wins), then at 04.
    pl = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (12) pulse();
    pl = 1'b0; ov = 1'b1; bs = 12; bsw = 12;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pl = 1'b1; ov = 1'b0; cur = 0; curw = 0;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) pulse();
    pl = 1'b0; ov = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
